// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scanline fetcher: fetch-state enum,
// Wishbone byte-select value, word size and the scanline base-address helper.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [3:0]  WB_SEL     = 4'hf;
  localparam int unsigned WORD_BYTES = 4;

  // Byte address of the first word of a scanline; wraps modulo 2^32.
  function automatic logic [31:0] line_addr(input logic [31:0] base,
                                            input logic [15:0] line,
                                            input int unsigned words);
    logic [31:0] stride;
    stride = 32'(words * WORD_BYTES);
    return base + ({16'd0, line} * stride);
  endfunction

endpackage

// File: rtl/vga_linefetch_if.sv
// Wishbone pipelined read bus between the line fetcher (master) and memory (slave).
interface vga_linefetch_if;
  logic        cyc_o;
  logic        stb_o;
  logic [31:0] adr_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stall_i;
  logic        ack_i;
  logic [31:0] dat_i;

  modport master (output cyc_o, stb_o, adr_o, we_o, sel_o,
                  input  stall_i, ack_i, dat_i);
  modport slave  (input  cyc_o, stb_o, adr_o, we_o, sel_o,
                  output stall_i, ack_i, dat_i);
endinterface

// File: rtl/linefetch_fifo.sv
// Single-clock synchronous FIFO with flush; DEPTH must be a power of two.
// Pop on empty is ignored; push on full is dropped unless a pop frees a slot.
module linefetch_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/vga_linefetch.sv
// Scanline prefetcher: reads LINE_WORDS words over pipelined Wishbone into a FIFO.
// Define VGA_LINEFETCH_UNDERFLOW_EN to enable the sticky pop-while-empty flag.
module vga_linefetch
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_WORDS = 160
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  vga_linefetch_if.master       wb,
  input  logic [31:0]           vgabase,
  input  logic [15:0]           line_num,
  input  logic                  start_i,
  input  logic                  pop_i,
  output logic [31:0]           data_o,
  output logic                  empty_o,
  output logic                  busy_o,
  output logic                  underflow_o
);

  localparam int IW = $clog2(LINE_WORDS + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = LW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [IW-1:0] issued_q, issued_d;
  logic [LW-1:0] outst_q, outst_d;
  logic [15:0]   line_q, line_d;

  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic [CW-1:0] credit_sum;
  logic          stb, accept, ack_ok, fetching, flush, push;

  // Credit counts words already buffered plus words still in flight.
  assign credit_sum = {1'b0, fifo_level} + {1'b0, outst_q};
  assign stb      = (state_q == ST_FETCH) && (issued_q < IW'(LINE_WORDS)) &&
                    (credit_sum < CW'(FIFO_DEPTH));
  assign accept   = stb & ~wb.stall_i;
  assign ack_ok   = wb.ack_i & (outst_q != '0);
  assign fetching = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign flush    = start_i & fetching;
  assign push     = ack_ok & fetching & ~flush & ~fifo_full;
  assign outst_d  = outst_q + LW'(accept) - LW'(ack_ok);

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    issued_d = issued_q;
    line_d   = line_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_FETCH;
          line_d   = line_num;
          adr_d    = line_addr(vgabase, line_num, LINE_WORDS);
          issued_d = '0;
        end
      end
      ST_FETCH: begin
        if (start_i) begin
          state_d = ST_FLUSH;
          line_d  = line_num;
        end else if (accept) begin
          adr_d    = adr_q + 32'(WORD_BYTES);
          issued_d = issued_q + 1'b1;
          if (issued_q == IW'(LINE_WORDS - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (start_i) begin
          state_d = ST_FLUSH;
          line_d  = line_num;
        end else if (ack_ok && outst_q == LW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (start_i) line_d = line_num;
        // Old requests must all be acknowledged before the new line starts.
        if (outst_q == '0) begin
          state_d  = ST_FETCH;
          adr_d    = line_addr(vgabase, start_i ? line_num : line_q, LINE_WORDS);
          issued_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      line_q   <= line_d;
    end
  end

  linefetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (wb.dat_i),
    .pop_i   (pop_i),
    .flush_i (flush),
    .data_o  (data_o),
    .level_o (fifo_level),
    .empty_o (empty_o),
    .full_o  (fifo_full)
  );

  assign wb.cyc_o = (state_q != ST_IDLE) && ((outst_q != '0) || stb);
  assign wb.stb_o = stb;
  assign wb.adr_o = adr_q;
  assign wb.we_o  = 1'b0;
  assign wb.sel_o = WB_SEL;
  assign busy_o   = (state_q != ST_IDLE);

`ifdef VGA_LINEFETCH_UNDERFLOW_EN
  logic uflow_q, uflow_d;

  always_comb begin
    uflow_d = uflow_q;
    if (start_i)                uflow_d = 1'b0;
    else if (pop_i && empty_o)  uflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) uflow_q <= 1'b0;
    else        uflow_q <= uflow_d;
  end

  assign underflow_o = uflow_q;
`else
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_linefetch.sv
// Randomized bench for vga_linefetch: queue-based memory slave and FIFO/line
// model; every output is checked on the falling clock edge.
module tb_vga_linefetch;
  import vga_pkg::*;

  localparam int FIFO_DEPTH = 16;
  localparam int LINE_WORDS = 160;
`ifdef VGA_LINEFETCH_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] vgabase;
  logic [15:0] line_num;
  logic        start_i, pop_i;
  logic [31:0] data_o;
  logic        empty_o, busy_o, underflow_o;

  vga_linefetch_if wb();

  vga_linefetch #(.FIFO_DEPTH(FIFO_DEPTH), .LINE_WORDS(LINE_WORDS)) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .wb          (wb),
    .vgabase     (vgabase),
    .line_num    (line_num),
    .start_i     (start_i),
    .pop_i       (pop_i),
    .data_o      (data_o),
    .empty_o     (empty_o),
    .busy_o      (busy_o),
    .underflow_o (underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] adr; int gen; } req_t;

  req_t        sq[$];        // requests accepted by the slave, not yet acked
  logic [31:0] mq[$];        // words the consumer should see, head first
  int          gen, m_issued, m_popped;
  logic [31:0] exp_adr, first_adr, last_adr;
  bit          m_uflow;
  int          stall_pct, ack_pct, pop_pct;
  bit          force_stall, do_start;
  logic [15:0] next_line;
  int          n_chk, n_err;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [31:0] base_of(input logic [15:0] ln);
    return vgabase + ({16'd0, ln} * 32'(LINE_WORDS * 4));
  endfunction

  function automatic bit m_busy();
    return (m_issued < LINE_WORDS) || (sq.size() != 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    req_t        e;
    bit          ack, stall, pop, acc, busy_now;
    logic [31:0] d;
    busy_now = m_busy();
    chk("empty", empty_o, mq.size() == 0);
    if (mq.size() != 0) chk("data", data_o, mq[0]);
    chk("busy", busy_o, busy_now);
    chk("cyc", wb.cyc_o, busy_now && (sq.size() != 0 || wb.stb_o));
    chk("uflow", underflow_o, m_uflow);
    stall = force_stall || ($urandom_range(99) < stall_pct);
    ack = 1'b0;
    d = $urandom;
    if (sq.size() != 0 && $urandom_range(99) < ack_pct) begin
      ack = 1'b1;
      e = sq.pop_front();
      d = memf(e.adr);
    end
    pop = ($urandom_range(99) < pop_pct);
    acc = wb.stb_o && !stall;
    if (acc) begin
      chk("adr", wb.adr_o, exp_adr);
      chk("issue_in_line", m_issued < LINE_WORDS, 1);
      sq.push_back('{wb.adr_o, gen});
      if (m_issued == 0) first_adr = wb.adr_o;
      last_adr = wb.adr_o;
      exp_adr  = exp_adr + 4;
      m_issued++;
    end
    wb.stall_i = stall;
    wb.ack_i   = ack;
    wb.dat_i   = d;
    pop_i      = pop;
    start_i    = do_start;
    line_num   = next_line;
    if (pop) begin
      if (mq.size() != 0) begin
        void'(mq.pop_front());
        m_popped++;
      end else begin
        m_uflow = UF_EN;
      end
    end
    if (do_start) begin
      if (busy_now) mq.delete();
      gen++;
      exp_adr  = base_of(next_line);
      m_issued = 0;
      m_uflow  = 1'b0;
    end
    if (ack && e.gen == gen) mq.push_back(d);
    do_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_line(input logic [15:0] ln);
    do_start  = 1'b1;
    next_line = ln;
    tick();
  endtask

  task automatic run_until_done(input int max);
    for (int i = 0; i < max && (m_busy() || mq.size() != 0); i++) tick();
  endtask

  task automatic wait_idle();
    stall_pct = 20; ack_pct = 80; pop_pct = 100; force_stall = 1'b0;
    run_until_done(4000);
    chk("idle_busy", busy_o, 0);
    chk("idle_empty", empty_o, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_i = 1'b0; pop_i = 1'b0;
    wb.stall_i = 1'b0; wb.ack_i = 1'b0; wb.dat_i = '0;
    @(posedge clk);
    @(negedge clk);
    sq.delete(); mq.delete();
    m_issued = LINE_WORDS; m_uflow = 1'b0; gen++;
    chk("rst_cyc", wb.cyc_o, 0);
    chk("rst_stb", wb.stb_o, 0);
    chk("rst_adr", wb.adr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_uflow", underflow_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_we", wb.we_o, 0);
    chk("rst_sel", wb.sel_o, 4'hf);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] hold_adr;
    n_chk = 0; n_err = 0; gen = 0; m_popped = 0;
    m_issued = LINE_WORDS; m_uflow = 1'b0; exp_adr = '0;
    first_adr = '0; last_adr = '0;
    do_start = 1'b0; force_stall = 1'b0; next_line = '0;
    vgabase = 32'h0000_1000; line_num = '0;
    rst_n = 1'b0; start_i = 1'b0; pop_i = 1'b0;
    wb.stall_i = 1'b0; wb.ack_i = 1'b0; wb.dat_i = '0;
    @(negedge clk);
    do_reset();

    // Full line, zero-wait slave, consumer always ready.
    stall_pct = 0; ack_pct = 100; pop_pct = 100; m_popped = 0;
    start_line(16'd2);
    run_until_done(1000);
    chk("line_first_adr", first_adr, 32'h0000_1500);
    chk("line_last_adr", last_adr, 32'h0000_177C);
    chk("line_popped", m_popped, LINE_WORDS);
    chk("line_busy_end", busy_o, 0);

    // No pops: credit stops issue at FIFO_DEPTH, then one request per pop.
    stall_pct = 0; ack_pct = 100; pop_pct = 0;
    start_line(16'd5);
    run(60);
    chk("credit_issued", m_issued, FIFO_DEPTH);
    chk("credit_stb", wb.stb_o, 0);
    chk("credit_full", empty_o, 0);
    for (int k = 1; k <= 3; k++) begin
      pop_pct = 100; tick();
      pop_pct = 0;   run(5);
      chk("credit_resume", m_issued, FIFO_DEPTH + k);
      chk("credit_stb_hold", wb.stb_o, 0);
    end
    wait_idle();

    // Five stall cycles mid-line: address and strobe held.
    stall_pct = 0; ack_pct = 100; pop_pct = 100;
    start_line(16'd7);
    run(20);
    hold_adr = exp_adr;
    force_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_adr", wb.adr_o, hold_adr);
      chk("stall_stb", wb.stb_o, 1);
    end
    force_stall = 1'b0;
    wait_idle();

    // Restart with three requests outstanding.
    stall_pct = 0; ack_pct = 100; pop_pct = 0;
    start_line(16'd3);
    run(5);
    force_stall = 1'b1; run(2);
    force_stall = 1'b0; ack_pct = 0; run(3);
    chk("flush_pre_empty", empty_o, 0);
    force_stall = 1'b1;
    start_line(16'd9);
    chk("flush_empty", empty_o, 1);
    force_stall = 1'b0; ack_pct = 100; pop_pct = 100;
    run_until_done(1000);
    chk("flush_new_first", first_adr, base_of(16'd9));
    wait_idle();

    // Pop while empty: sticky flag when enabled, cleared by start.
    pop_pct = 100; tick();
    pop_pct = 0;   tick();
    chk("uflow_set", underflow_o, UF_EN);
    start_line(16'd1);
    chk("uflow_clr", underflow_o, 0);
    wait_idle();

    // Randomized lines, some restarted mid-line, including an address wrap.
    for (int l = 0; l < 5; l++) begin
      vgabase   = (l == 4) ? 32'hFFFF_0000 : ($urandom & 32'hFFFF_FFFC);
      stall_pct = $urandom_range(40);
      ack_pct   = $urandom_range(100, 30);
      pop_pct   = $urandom_range(100, 20);
      start_line((l == 4) ? 16'hFFFF : 16'($urandom_range(479)));
      run($urandom_range(400, 100));
      if ($urandom_range(1) == 1) start_line(16'($urandom_range(479)));
      wait_idle();
    end

    // Reset while draining: outputs return to reset values, late ack dropped.
    vgabase = 32'h0000_1000;
    stall_pct = 0; ack_pct = 100; pop_pct = 100;
    start_line(16'd4);
    for (int i = 0; i < 1000 && m_issued < LINE_WORDS; i++) tick();
    chk("drain_busy", busy_o, 1);
    do_reset();
    wb.ack_i = 1'b1; wb.dat_i = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    wb.ack_i = 1'b0;
    chk("late_ack_empty", empty_o, 1);
    chk("late_ack_cyc", wb.cyc_o, 0);
    chk("late_ack_busy", busy_o, 0);
    pop_pct = 0;
    run(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
